// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one data-memory port between two req/ack masters.
// Define ARB_LOCK_EN to add lock0/lock1 inputs and the HOLD state for atomic sequences.
module mem_arbiter #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
`ifdef ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} state_t;
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
    state_t     state;
    logic [1:0] cnt;
    logic       ptr, sel, wr, g, go;
`ifdef ARB_LOCK_EN
    logic lock_sel;
    assign lock_sel = sel ? lock1 : lock0;
`endif
    // HOLD only ever re-grants the port that owns the lock
    assign g    = state == HOLD ? sel : req1 & (~req0 | ptr);
    assign go   = state == HOLD ? (sel ? req1 : req0) : req0 | req1;
    assign busy = state != IDLE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            ptr       <= 1'b0;
            cnt       <= '0;
            sel       <= 1'b0;
            wr        <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
`ifdef ARB_LOCK_EN
                    if (state == HOLD && !lock_sel) begin
                        ptr   <= ~sel;
                        state <= IDLE;
                    end else
`endif
                    if (go) begin
                        sel       <= g;
                        gnt       <= g ? 2'b10 : 2'b01;
                        mem_addr  <= g ? addr1 : addr0;
                        mem_wdata <= g ? wdata1 : wdata0;
                        mem_we    <= g ? we1 : we0;
                        wr        <= g ? we1 : we0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_we <= 1'b0;
                    cnt    <= LAT_M1;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        if (!wr) rdata <= mem_rdata;
                        ack0  <= ~sel;
                        ack1  <= sel;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    gnt  <= '0;
`ifdef ARB_LOCK_EN
                    if (lock_sel) state <= HOLD;
                    else
`endif
                    begin
                        ptr   <= ~sel;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single data-memory port (address, write data, write enable, read data) between the multi-cycle processor (port 0) and a secondary master (port 1, loader/DMA/debug).
- Each requester uses a req/ack handshake. The arbiter sequences one memory access at a time, waits the memory read latency and returns the read data.
- Round-robin priority prevents either master from starving the other.

Parameters:
- ADDR_W, 7, memory address width.
- DATA_W, 16, data width.
- MEM_LAT, 1, synchronous memory read latency in cycles (valid range 1..3).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 (processor) request; held high until ack0.
- we0  in  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  in  ADDR_W  port 0 address; stable while req0 is high.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 completion pulse, one cycle.
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1.
- rdata  out  DATA_W  read data, valid in the cycle ack0 or ack1 is high.
- gnt  out  2  one-hot owner of the current transaction; 00 when idle.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_we  out  1  memory write enable, registered, one-cycle pulse.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the address is presented.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; gnt=00; ack0=ack1=0; mem_we=0; mem_addr=0; mem_wdata=0; rdata=0; priority pointer favours port 0; wait counter=0.
- All outputs are registered. Reset asserted mid-transaction aborts it: at the next edge the block is in IDLE, mem_we=0, no ack is issued, and the aborted requester must re-request.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If only one req is high, grant that port.
  - If both are high, grant the port selected by the priority pointer.
  - On grant: latch the granted port's addr/wdata/we into mem_addr, mem_wdata, mem_we; set gnt; go to ISSUE.
- ISSUE: one cycle; mem_we is high here only for writes. Go to WAIT with counter=MEM_LAT-1; mem_we deasserts.
- WAIT: decrement the counter. When the counter is 0, capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to RESP.
- RESP: ack of the granted port is high for exactly this cycle. Point the priority pointer at the other port, clear gnt, go to IDLE.
- Timing for MEM_LAT=1: req sampled at edge E0; ISSUE E0–E1; WAIT E1–E2; ack high E2–E3. Minimum cost is 4 cycles per access including the IDLE sample.
- Requesters must drop req (or present a new transaction) after seeing ack. IDLE samples req no earlier than one cycle after RESP, so a held req is treated as a new request.
- Requests arriving while busy are ignored until IDLE. The requester keeps req high; no loss and no queueing.
- If req drops before ack, the transaction still completes and ack still pulses; the requester ignores it.
- mem_addr and mem_wdata hold their last values when idle. mem_we is never high outside ISSUE.
- Both ack0 and ack1 are never high in the same cycle.

Optional Feature:
- Macro ARB_LOCK_EN.
- When defined:
  - Adds inputs lock0 and lock1, plus state HOLD.
  - If the granted port's lock is high during RESP, the next state is HOLD instead of IDLE, and the pointer is not advanced.
  - HOLD behaves like IDLE but grants only the locking port; the other port's req is ignored.
  - HOLD returns to IDLE when the locking port's lock is low, with the pointer advanced.
  - Supports atomic read-modify-write.
- When undefined: no lock ports and no HOLD state; lock behaviour is absent.

Test Plan:
- Reset, then port 0 read of addr 0x05 with memory word 0x1234 -> mem_addr=0x05 from E0; ack0 high at E2–E3; rdata=0x1234; mem_we never high.
- Port 1 write of 0xBEEF to addr 0x10 -> mem_we high exactly one cycle (E0–E1) with mem_addr=0x10 and mem_wdata=0xBEEF; ack1 high at E2; rdata unchanged.
- req0 and req1 both held continuously, each re-requesting after its ack, over 6 accesses -> grant order 0,1,0,1,0,1; no ack overlap.
- MEM_LAT=3, port 0 read -> ack0 and rdata valid exactly 4 cycles after ISSUE begins; rdata equals mem_rdata sampled at the end of WAIT.
- Reset asserted during WAIT of a port 1 read -> the next cycle shows busy=0, gnt=00, no ack1; a re-issued req1 then completes normally.
- ARB_LOCK_EN: port 1 holds lock1 across two accesses while req0 is pending -> both port 1 accesses complete before any gnt to port 0; port 0 is served immediately after lock1 drops.
